// File: rtl/ex_operand_stage.sv
// Purpose : EX-stage operand unit; MEM/WB forwarding, load-use detection and registered ALU operands.
// Latency : 1 cycle from accept to out_valid; back-to-back accepts give 1 instruction per cycle.
// Backpres: out_ready=0 holds the operand pair and drops in_ready; a load-use hazard also drops in_ready.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         handshake with the ID/EX register
//   alua_sel, alub_sel          operand source selects
//   rs_addr, rt_addr            source register numbers
//   rdata1, rdata2, ext_imm     register-file data and extended immediate
//   mem_* / wb_*                writeback info of the instructions in MEM and WB
//   flush                       kills the registered operand pair
//   out_valid / out_ready       handshake with ALU/MUL issue
//   alu_a, alu_b                registered operands
//   load_use_stall, stall_cnt   hazard indication and saturating stall-cycle count
module ex_operand_stage #(
  parameter int WIDTH       = 32,
  parameter int RA_W        = 5,
  parameter int SHIFT_CONST = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alua_sel,
  input  logic [1:0]       alub_sel,
  input  logic [RA_W-1:0]  rs_addr,
  input  logic [RA_W-1:0]  rt_addr,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic [WIDTH-1:0] ext_imm,
  input  logic             mem_we,
  input  logic [RA_W-1:0]  mem_waddr,
  input  logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_is_load,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_waddr,
  input  logic [WIDTH-1:0] wb_wdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rs_used;
  logic             rt_used;
  logic             accept;

  // Forwarding: WB is applied first so a matching MEM entry overrides it.
  // Register 0 is never a forwarding target.
  always_comb begin
    rs_val = rdata1;
    if (wb_we && (rs_addr == wb_waddr) && (rs_addr != '0))
      rs_val = wb_wdata;
    if (mem_we && (rs_addr == mem_waddr) && (rs_addr != '0))
      rs_val = mem_wdata;

    rt_val = rdata2;
    if (wb_we && (rt_addr == wb_waddr) && (rt_addr != '0))
      rt_val = wb_wdata;
    if (mem_we && (rt_addr == mem_waddr) && (rt_addr != '0))
      rt_val = mem_wdata;
  end

  always_comb begin
    op_a = '0;
    case (alua_sel)
      2'b00:   op_a = rs_val;
      2'b01:   op_a = rt_val;
      2'b10:   op_a = ext_imm;
      default: op_a = '0;
    endcase

    op_b = '0;
    case (alub_sel)
      2'b00:   op_b = rt_val;
      2'b01:   op_b = ext_imm;
      2'b10:   op_b = '0;
      default: op_b = WIDTH'(SHIFT_CONST);
    endcase
  end

  // Only sources actually feeding an operand can cause a load-use hazard.
  assign rs_used = (alua_sel == 2'b00);
  assign rt_used = (alua_sel == 2'b01) || (alub_sel == 2'b00);

  assign load_use_stall = in_valid && mem_is_load && mem_we && (mem_waddr != '0) &&
                          ((rs_used && (rs_addr == mem_waddr)) ||
                           (rt_used && (rt_addr == mem_waddr)));

  assign in_ready = (!out_valid || out_ready) && !load_use_stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      stall_cnt <= '0;
    end else begin
      // Flush beats both accept and hold; the operand values are left as-is.
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        alu_a     <= op_a;
        alu_b     <= op_b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_use_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;
  localparam int SHC   = 16;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alua_sel;
  logic [1:0]       alub_sel;
  logic [RA_W-1:0]  rs_addr;
  logic [RA_W-1:0]  rt_addr;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic [WIDTH-1:0] ext_imm;
  logic             mem_we;
  logic [RA_W-1:0]  mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_is_load;
  logic             wb_we;
  logic [RA_W-1:0]  wb_waddr;
  logic [WIDTH-1:0] wb_wdata;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             load_use_stall;
  logic [CNT_W-1:0] stall_cnt;

  ex_operand_stage #(
    .WIDTH(WIDTH), .RA_W(RA_W), .SHIFT_CONST(SHC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alua_sel(alua_sel), .alub_sel(alub_sel), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rdata1(rdata1), .rdata2(rdata2), .ext_imm(ext_imm),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ncomp = 0;
  int nfail = 0;

  // Reference state: what the consumer should see, plus raw stall cycles since reset.
  bit        m_valid;
  bit [31:0] m_a, m_b;
  int        m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Youngest in-flight writer (MEM, then WB) that targets a nonzero register wins.
  function automatic bit [31:0] source_value(input bit [4:0] addr, input bit [31:0] rf);
    bit        we   [2];
    bit [4:0]  dst  [2];
    bit [31:0] dat  [2];
    we[0] = mem_we; dst[0] = mem_waddr; dat[0] = mem_wdata;
    we[1] = wb_we;  dst[1] = wb_waddr;  dat[1] = wb_wdata;
    if (addr == 0) return rf;
    for (int i = 0; i < 2; i++)
      if (we[i] && dst[i] == addr) return dat[i];
    return rf;
  endfunction

  // One clock: check combinational outputs, advance, check registered outputs.
  task automatic step();
    bit [31:0] rsv, rtv, ea, eb;
    bit        rs_use, rt_use, hz, rdy;
    #1;
    rsv    = source_value(rs_addr, rdata1);
    rtv    = source_value(rt_addr, rdata2);
    rs_use = (alua_sel == 2'd0);
    rt_use = (alua_sel == 2'd1) || (alub_sel == 2'd0);
    hz     = in_valid && mem_is_load && mem_we && (mem_waddr != 0) &&
             ((rs_use && rs_addr == mem_waddr) || (rt_use && rt_addr == mem_waddr));
    rdy    = (!m_valid || out_ready) && !hz;
    chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, hz});
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    ea = (alua_sel == 0) ? rsv : (alua_sel == 1) ? rtv : (alua_sel == 2) ? ext_imm : 32'd0;
    eb = (alub_sel == 0) ? rtv : (alub_sel == 1) ? ext_imm : (alub_sel == 2) ? 32'd0 : SHC;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_stalls = 0;
    end else begin
      if (hz) m_stalls++;
      if (flush)                 m_valid = 0;
      else if (in_valid && rdy)  begin m_valid = 1; m_a = ea; m_b = eb; end
      else if (out_ready)        m_valid = 0;
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("stall_cnt", {30'd0, stall_cnt}, (m_stalls > CMAX) ? CMAX : m_stalls);
  endtask

  task automatic idle_inputs();
    rst_n = 1; in_valid = 0; alua_sel = 0; alub_sel = 0; rs_addr = 0; rt_addr = 0;
    rdata1 = 0; rdata2 = 0; ext_imm = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0;
    mem_is_load = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0; flush = 0; out_ready = 1;
  endtask

  bit [31:0] held_a, held_b;

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_stalls = 0;
    idle_inputs();

    // Reset
    rst_n = 0; step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", {30'd0, stall_cnt}, 32'd0);
    rst_n = 1;

    // Basic select
    in_valid = 1; alua_sel = 2'b00; alub_sel = 2'b11; rs_addr = 1; rdata1 = 32'h1234;
    step();
    chk("basic_a", alu_a, 32'h1234);
    chk("basic_b", alu_b, 32'h10);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);

    // Forward priority
    rs_addr = 5; rdata1 = 32'h1111;
    mem_we = 1; mem_waddr = 5; mem_wdata = 32'hAAAA;
    wb_we = 1;  wb_waddr = 5;  wb_wdata = 32'hBBBB;
    step();
    chk("fwd_mem", alu_a, 32'hAAAA);
    mem_we = 0;
    step();
    chk("fwd_wb", alu_a, 32'hBBBB);

    // Load-use on rt, then WB forward
    wb_we = 0; alua_sel = 2'b10; ext_imm = 32'h9; alub_sel = 2'b00; rt_addr = 7; rdata2 = 32'h3;
    mem_is_load = 1; mem_we = 1; mem_waddr = 7; mem_wdata = 32'hDEAD;
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("lu_cnt", {30'd0, stall_cnt}, 32'd1);
    mem_is_load = 0; mem_we = 0; wb_we = 1; wb_waddr = 7; wb_wdata = 32'h55;
    step();
    chk("lu_fwd_b", alu_b, 32'h55);
    wb_we = 0;

    // Back-pressure for 3 cycles with new inputs presented
    held_a = alu_a; held_b = alu_b;
    out_ready = 0; alua_sel = 2'b01; alub_sel = 2'b01; rdata2 = 32'hCAFE; ext_imm = 32'hF00D;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_a", alu_a, held_a);
      chk("bp_hold_b", alu_b, held_b);
    end
    out_ready = 1;
    step();
    chk("bp_new_a", alu_a, 32'hCAFE);
    chk("bp_new_b", alu_b, 32'hF00D);

    // Flush with concurrent accept; flush with out_ready=0
    flush = 1; step();
    chk("flush_acc", {31'd0, out_valid}, 32'd0);
    flush = 0; step();
    out_ready = 0; flush = 1; step();
    chk("flush_hold", {31'd0, out_valid}, 32'd0);
    flush = 0; step();

    // Reset mid-hold
    rst_n = 0; step();
    chk("rst_hold_a", alu_a, 32'd0);
    chk("rst_hold_v", {31'd0, out_valid}, 32'd0);
    rst_n = 1; out_ready = 1;

    // Register zero never forwarded
    alua_sel = 2'b00; rs_addr = 0; rdata1 = 32'h77; mem_we = 1; mem_waddr = 0; mem_wdata = 32'hBEEF;
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hF1F1;
    step();
    chk("zero_a", alu_a, 32'h77);
    wb_we = 0;

    // Saturation: 5 stall cycles from reset
    rst_n = 0; step(); rst_n = 1;
    alua_sel = 2'b00; rs_addr = 3; mem_we = 1; mem_waddr = 3; mem_is_load = 1;
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt", {30'd0, stall_cnt}, 32'd3);
    idle_inputs();
    step();

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      in_valid    = $urandom_range(0, 3) != 0;
      alua_sel    = 2'($urandom_range(0, 3));
      alub_sel    = 2'($urandom_range(0, 3));
      rs_addr     = 5'($urandom_range(0, 3));
      rt_addr     = 5'($urandom_range(0, 3));
      rdata1      = $urandom;
      rdata2      = $urandom;
      ext_imm     = $urandom;
      mem_we      = $urandom_range(0, 1) != 0;
      mem_waddr   = 5'($urandom_range(0, 3));
      mem_wdata   = $urandom;
      mem_is_load = $urandom_range(0, 2) == 0;
      wb_we       = $urandom_range(0, 1) != 0;
      wb_waddr    = 5'($urandom_range(0, 3));
      wb_wdata    = $urandom;
      flush       = $urandom_range(0, 9) == 0;
      out_ready   = $urandom_range(0, 2) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
